// File: rtl/i2s_tx.sv
// I2S transmitter: a one-entry stereo holding register feeds a 2*SLOT_W frame shift register.
// BCLK and LRCLK come from clk. Optional macro I2S_TX_UNDERRUN_REPEAT_EN repeats the last frame on underrun.
module i2s_tx #(
    parameter int CLK_DIV  = 6,
    parameter int SAMPLE_W = 18,
    parameter int SLOT_W   = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [SAMPLE_W-1:0] in_left,
    input  logic [SAMPLE_W-1:0] in_right,
    output logic                BCLK,
    output logic                LRCLK,
    output logic                SDATA,
    output logic                underrun
);

    localparam int FRAME_W = 2 * SLOT_W;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int K_W     = $clog2(FRAME_W);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [K_W-1:0]   K_LAST   = K_W'(FRAME_W - 1);
    localparam logic [K_W-1:0]   LR_RISE  = K_W'(SLOT_W - 1);

    // Left sample MSB-first at the top of the frame, right sample at the top of the lower slot.
    function automatic logic [FRAME_W-1:0] pack_frame(input logic [SAMPLE_W-1:0] l,
                                                      input logic [SAMPLE_W-1:0] r);
        logic [FRAME_W-1:0] f;
        f = '0;
        f[FRAME_W-1 -: SAMPLE_W] = l;
        f[SLOT_W-1 -: SAMPLE_W]  = r;
        return f;
    endfunction

    logic [DIV_W-1:0]    div_cnt;
    logic [K_W-1:0]      k;
    logic [K_W-1:0]      k_next;
    logic                full;
    logic [SAMPLE_W-1:0] hold_left;
    logic [SAMPLE_W-1:0] hold_right;
    logic [FRAME_W-1:0]  shreg;
    logic [FRAME_W-1:0]  idle_frame;
    logic [FRAME_W-1:0]  load_frame;
    logic                div_tc;
    logic                fall_evt;
    logic                frame_load;
    logic                accept;

`ifdef I2S_TX_UNDERRUN_REPEAT_EN
    logic [SAMPLE_W-1:0] last_left;
    logic [SAMPLE_W-1:0] last_right;
`endif

    assign div_tc     = (div_cnt == DIV_LAST);
    assign fall_evt   = div_tc && BCLK;
    assign frame_load = fall_evt && (k == K_LAST);
    assign accept     = in_valid && !full;
    assign in_ready   = !full;
    assign k_next     = frame_load ? '0 : k + K_W'(1);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no latch can be inferred.
        idle_frame = '0;
`ifdef I2S_TX_UNDERRUN_REPEAT_EN
        idle_frame = pack_frame(last_left, last_right);
`endif
        load_frame = full ? pack_frame(hold_left, hold_right) : idle_frame;
    end

    // NOTE: sample storage carries no reset; full alone decides whether its contents are used.
    always_ff @(posedge clk) begin
        if (accept) begin
            hold_left  <= in_left;
            hold_right <= in_right;
        end
    end

    // NOTE: all state updates use <= so each register sees only pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt  <= '0;
            k        <= K_LAST;
            full     <= 1'b0;
            shreg    <= '0;
            BCLK     <= 1'b0;
            LRCLK    <= 1'b0;
            SDATA    <= 1'b0;
            underrun <= 1'b0;
`ifdef I2S_TX_UNDERRUN_REPEAT_EN
            last_left  <= '0;
            last_right <= '0;
`endif
        end else begin
            underrun <= 1'b0;

            if (div_tc) begin
                div_cnt <= '0;
                BCLK    <= !BCLK;
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end

            // Frame logic advances only when BCLK falls, so SDATA/LRCLK are stable at the rise.
            if (fall_evt) begin
                k     <= k_next;
                LRCLK <= (k_next >= LR_RISE) && (k_next != K_LAST);
                if (frame_load) begin
                    SDATA    <= load_frame[FRAME_W-1];
                    shreg    <= load_frame << 1;
                    underrun <= !full;
                    if (full) begin
                        full <= 1'b0;
`ifdef I2S_TX_UNDERRUN_REPEAT_EN
                        last_left  <= hold_left;
                        last_right <= hold_right;
`endif
                    end
                end else begin
                    SDATA <= shreg[FRAME_W-1];
                    shreg <= shreg << 1;
                end
            end

            // Only possible while empty, so it never collides with the load clearing full.
            if (accept) begin
                full <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_i2s_tx.sv
// Self-checking bench for i2s_tx: per-cycle comparison against an arithmetic reference model,
// a table of bit-order vectors, and directed handshake/underrun/reset sequences.
module tb_i2s_tx;

    localparam int CLK_DIV   = 6;
    localparam int SAMPLE_W  = 18;
    localparam int SLOT_W    = 32;
    localparam int FRAME_W   = 2 * SLOT_W;
    localparam int FRAME_CYC = FRAME_W * 2 * CLK_DIV;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                in_valid = 1'b0;
    logic [SAMPLE_W-1:0] in_left = '0;
    logic [SAMPLE_W-1:0] in_right = '0;
    logic                in_ready;
    logic                BCLK;
    logic                LRCLK;
    logic                SDATA;
    logic                underrun;

    always #5 clk = ~clk;

    i2s_tx #(
        .CLK_DIV (CLK_DIV),
        .SAMPLE_W(SAMPLE_W),
        .SLOT_W  (SLOT_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_left (in_left),
        .in_right(in_right),
        .BCLK    (BCLK),
        .LRCLK   (LRCLK),
        .SDATA   (SDATA),
        .underrun(underrun)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;
    bit lr_chk = 1'b0;

    // Reference model state: time in non-reset edges, frame position from plain arithmetic.
    int                  m_t = 0;
    int                  m_kk = 0;
    int                  m_p;
    bit                  m_started = 1'b0;
    bit                  m_rise = 1'b0;
    bit                  m_fall;
    bit                  m_acc;
    bit                  m_full = 1'b0;
    logic [SAMPLE_W-1:0] m_hl = '0, m_hr = '0;
    logic [SAMPLE_W-1:0] m_fl = '0, m_fr = '0;
    logic [SAMPLE_W-1:0] m_ll = '0, m_lr = '0;
    logic [SAMPLE_W-1:0] m_smp;
    logic                e_bclk = 1'b0, e_lr = 1'b0, e_sd = 1'b0, e_ur = 1'b0, e_ready = 1'b1;

    typedef struct {
        logic [FRAME_W-1:0] bits;
        bit                 ur;
    } frame_t;

    frame_t             cap_q[$];
    logic [FRAME_W-1:0] cap = '0;
    bit                 cur_ur = 1'b0;

    typedef struct {
        logic [SAMPLE_W-1:0] l;
        logic [SAMPLE_W-1:0] r;
        logic [SLOT_W-1:0]   exp_l;
        logic [SLOT_W-1:0]   exp_r;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", name, m_t, act, exp);
        end
    endtask

    function automatic logic [FRAME_W-1:0] frame_bits(input logic [SAMPLE_W-1:0] l,
                                                      input logic [SAMPLE_W-1:0] r);
        logic [FRAME_W-1:0] f;
        f = '0;
        for (int p = 0; p < SAMPLE_W; p++) begin
            f[FRAME_W-1-p] = l[SAMPLE_W-1-p];
            f[SLOT_W-1-p]  = r[SAMPLE_W-1-p];
        end
        return f;
    endfunction

    always @(posedge clk) begin
        m_acc = in_valid && !m_full;
        if (rst) begin
            m_t = 0; m_started = 1'b0; m_rise = 1'b0; m_full = 1'b0;
            m_fl = '0; m_fr = '0; m_ll = '0; m_lr = '0;
            e_bclk = 1'b0; e_lr = 1'b0; e_sd = 1'b0; e_ur = 1'b0; e_ready = 1'b1;
        end else begin
            m_t++;
            e_bclk = ((m_t / CLK_DIV) % 2) == 1;
            m_rise = (m_t % (2 * CLK_DIV)) == CLK_DIV;
            m_fall = (m_t % (2 * CLK_DIV)) == 0;
            e_ur   = 1'b0;
            if (m_fall) begin
                m_kk = (m_t / (2 * CLK_DIV) - 1) % FRAME_W;
                m_started = 1'b1;
                if (m_kk == 0) begin
                    e_ur = !m_full;
                    if (m_full) begin
                        m_fl = m_hl; m_fr = m_hr; m_ll = m_hl; m_lr = m_hr;
                        m_full = 1'b0;
                    end else begin
`ifdef I2S_TX_UNDERRUN_REPEAT_EN
                        m_fl = m_ll; m_fr = m_lr;
`else
                        m_fl = '0; m_fr = '0;
`endif
                    end
                end
                e_lr  = (m_kk >= SLOT_W - 1) && (m_kk <= FRAME_W - 2);
                m_p   = m_kk % SLOT_W;
                m_smp = (m_kk < SLOT_W) ? m_fl : m_fr;
                e_sd  = (m_p < SAMPLE_W) ? m_smp[SAMPLE_W-1-m_p] : 1'b0;
            end
            if (m_acc) begin
                m_hl = in_left; m_hr = in_right; m_full = 1'b1;
            end
            e_ready = !m_full;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("bclk",     64'(BCLK),     64'(e_bclk));
            check("lrclk",    64'(LRCLK),    64'(e_lr));
            check("sdata",    64'(SDATA),    64'(e_sd));
            check("in_ready", 64'(in_ready), 64'(e_ready));
            check("underrun", 64'(underrun), 64'(e_ur));
        end
    end

    // Capture SDATA at each BCLK rise into the bit position the frame counter says it belongs to.
    always @(negedge clk) begin
        if (rst) begin
            cap_q.delete();
            cur_ur = 1'b0;
        end else if (chk_en) begin
            if (underrun) cur_ur = 1'b1;
            if (m_rise && m_started) begin
                cap[FRAME_W-1-m_kk] = SDATA;
                if (lr_chk) begin
                    if (m_kk == SLOT_W - 2)  check("lrclk_before_rise", 64'(LRCLK), 64'd0);
                    if (m_kk == SLOT_W - 1)  check("lrclk_rise",        64'(LRCLK), 64'd1);
                    if (m_kk == FRAME_W - 2) check("lrclk_before_fall", 64'(LRCLK), 64'd1);
                    if (m_kk == FRAME_W - 1) check("lrclk_fall",        64'(LRCLK), 64'd0);
                end
                if (m_kk == FRAME_W - 1) begin
                    cap_q.push_back('{bits: cap, ur: cur_ur});
                    cur_ur = 1'b0;
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic send(input logic [SAMPLE_W-1:0] l, input logic [SAMPLE_W-1:0] r,
                        output int edge_no);
        bit ok = 1'b0;
        in_valid = 1'b1;
        in_left  = l;
        in_right = r;
        for (int i = 0; i < 2 * FRAME_CYC && !ok; i++) begin
            ok = in_ready;
            @(negedge clk);
        end
        edge_no  = m_t;
        in_valid = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL send_timeout: got no accept, required accept within %0d cycles", 2 * FRAME_CYC);
        end
    endtask

    task automatic wait_frames(input int n);
        int budget;
        int i;
        budget = (n + 1) * FRAME_CYC + 8 * CLK_DIV;
        i = 0;
        while (cap_q.size() < n && i < budget) begin
            @(negedge clk);
            i++;
        end
        checks++;
        if (cap_q.size() < n) begin
            errors++;
            $display("FAIL frame_wait: got %0d frames required %0d", cap_q.size(), n);
        end
    endtask

    task automatic check_frame(input string name, input int idx,
                               input logic [FRAME_W-1:0] exp_bits, input bit exp_ur);
        if (idx < cap_q.size()) begin
            check({name, "_bits"}, 64'(cap_q[idx].bits), 64'(exp_bits));
            check({name, "_ur"},   64'(cap_q[idx].ur),   64'(exp_ur));
        end else begin
            checks++;
            errors++;
            $display("FAIL %s: got %0d frames required frame %0d", name, cap_q.size(), idx);
        end
    endtask

    initial begin
        int e;
        int first_rise;
        int first_ur;
        logic [SAMPLE_W-1:0] sa, sb;
        logic [FRAME_W-1:0] rep;
        int thresh[5];

        vecs[0] = '{18'h2AAAA, 18'h00001, 32'hAAAA_8000, 32'h0000_4000};
        vecs[1] = '{18'h3FFFF, 18'h00000, 32'hFFFF_C000, 32'h0000_0000};
        vecs[2] = '{18'h20000, 18'h15555, 32'h8000_0000, 32'h5555_4000};
        vecs[3] = '{18'h12345, 18'h3FFFF, 32'h48D1_4000, 32'hFFFF_C000};
        vecs[4] = '{18'h00000, 18'h20000, 32'h0000_0000, 32'h8000_0000};

        // Reset values and first BCLK rise / first load timing.
        do_reset();
        chk_en = 1'b1;
        check("rst_bclk",     64'(BCLK),     64'd0);
        check("rst_lrclk",    64'(LRCLK),    64'd0);
        check("rst_sdata",    64'(SDATA),    64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_underrun", 64'(underrun), 64'd0);
        first_rise = -1;
        first_ur = -1;
        for (int i = 1; i <= 4 * CLK_DIV; i++) begin
            @(negedge clk);
            if (BCLK && first_rise < 0) first_rise = i;
            if (underrun && first_ur < 0) first_ur = i;
            if (i == 2 * CLK_DIV) check("first_fall_bclk", 64'(BCLK), 64'd0);
        end
        check("first_rise_edge",     64'(first_rise), 64'(CLK_DIV));
        check("first_underrun_edge", 64'(first_ur),   64'(2 * CLK_DIV));

        // Bit order: one sample queued before the first load goes out in that frame.
        for (int v = 0; v < 5; v++) begin
            do_reset();
            lr_chk = (v == 0);
            send(vecs[v].l, vecs[v].r, e);
            wait_frames(1);
            check_frame($sformatf("vec%0d", v), 0, {vecs[v].exp_l, vecs[v].exp_r}, 1'b0);
            lr_chk = 1'b0;
        end

        // Backpressure: B waits for the load that consumes A, then goes out in the next frame.
        do_reset();
        sa = 18'h1ABCD;
        sb = 18'h0F0F3;
        send(sa, 18'h2468A, e);
        check("bp_ready_low", 64'(in_ready), 64'd0);
        send(sb, 18'h33333, e);
        check("bp_b_accept_edge", 64'(e), 64'(2 * CLK_DIV + 1));
        wait_frames(2);
        check_frame("bp_a", 0, frame_bits(sa, 18'h2468A), 1'b0);
        check_frame("bp_b", 1, frame_bits(sb, 18'h33333), 1'b0);

        // Underrun after a single sample.
        do_reset();
        send(18'h2C3A5, 18'h15A5A, e);
        wait_frames(3);
`ifdef I2S_TX_UNDERRUN_REPEAT_EN
        rep = frame_bits(18'h2C3A5, 18'h15A5A);
`else
        rep = '0;
`endif
        check_frame("ur_f0", 0, frame_bits(18'h2C3A5, 18'h15A5A), 1'b0);
        check_frame("ur_f1", 1, rep, 1'b1);
        check_frame("ur_f2", 2, rep, 1'b1);

        // Sample offered exactly on the load edge while empty.
        do_reset();
        for (int i = 0; i < 4 * CLK_DIV && m_t != 2 * CLK_DIV - 1; i++) @(negedge clk);
        check("sim_align", 64'(m_t), 64'(2 * CLK_DIV - 1));
        in_valid = 1'b1;
        in_left  = 18'h3C3C3;
        in_right = 18'h0A5A5;
        @(negedge clk);
        check("sim_underrun", 64'(underrun), 64'd1);
        check("sim_ready",    64'(in_ready), 64'd0);
        in_valid = 1'b0;
        wait_frames(2);
        check_frame("sim_f0", 0, '0, 1'b1);
        check_frame("sim_f1", 1, frame_bits(18'h3C3C3, 18'h0A5A5), 1'b0);

        // Reset in the middle of a frame with a second sample held.
        do_reset();
        send(18'h11111, 18'h22222, e);
        send(18'h33333, 18'h04444, e);
        for (int i = 0; i < 2 * FRAME_CYC && !(m_started && m_kk == 20); i++) @(negedge clk);
        check("mid_align", 64'(m_kk), 64'd20);
        rst = 1'b1;
        @(negedge clk);
        check("mid_bclk",     64'(BCLK),     64'd0);
        check("mid_lrclk",    64'(LRCLK),    64'd0);
        check("mid_sdata",    64'(SDATA),    64'd0);
        check("mid_in_ready", 64'(in_ready), 64'd1);
        check("mid_underrun", 64'(underrun), 64'd0);
        rst = 1'b0;
        wait_frames(2);
        check_frame("mid_f0", 0, '0, 1'b1);
        check_frame("mid_f1", 1, '0, 1'b1);

        // Random traffic at varying offered load, checked cycle by cycle against the model.
        do_reset();
        thresh = '{2, 300, 1, 40, 1000};
        for (int c = 0; c < 5 * FRAME_CYC; c++) begin
            in_valid = ($urandom_range(0, 999) < thresh[c / FRAME_CYC]);
            in_left  = SAMPLE_W'($urandom);
            in_right = SAMPLE_W'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b0;
        repeat (4) @(negedge clk);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not reach its summary in time");
        $fatal(1);
    end

endmodule

// File: doc/i2s_tx.md
# i2s_tx

Serial I2S transmitter. It takes parallel stereo samples through a valid/ready handshake and drives BCLK, LRCLK and serial data to an external I2S DAC or codec. It generates all bit and frame clocks from the 50 MHz system clock. It is the playback-side counterpart of the microphone capture path and uses the same BCLK/LRCLK framing, so the two can share a frame rate.

## Interface
- `CLK_DIV`, default 6: BCLK half-period in `clk` cycles. The default gives 50 MHz / 12 ≈ 4.17 MHz. Must be ≥ 2.
- `SAMPLE_W`, default 18: sample width in bits, two's complement, MSB first.
- `SLOT_W`, default 32: BCLK cycles per channel slot. Must be ≥ `SAMPLE_W`.
- `clk`, input, 1: system clock, 50 MHz.
- `rst`, input, 1: reset, synchronous, active-high.
- `in_valid`, input, 1: `in_left`/`in_right` hold a stereo sample.
- `in_ready`, output, 1: the holding register is empty.
- `in_left`, input, `SAMPLE_W`: left-channel sample.
- `in_right`, input, `SAMPLE_W`: right-channel sample.
- `BCLK`, output, 1: bit clock, 50% duty, registered.
- `LRCLK`, output, 1: word select; 0 = left, 1 = right. Registered.
- `SDATA`, output, 1: serial data. Changes only on BCLK falling edges; registered.
- `underrun`, output, 1: one-`clk` pulse when a frame starts with no sample held.

## Operation
- **Clock divider.**
  - `div_cnt` counts 0..`CLK_DIV`-1.
  - On terminal count it wraps to 0 and BCLK toggles.
  - A "fall event" is a clk edge where BCLK goes 1→0. All frame logic advances only on fall events.
- **Frame position.**
  - `k` counts 0..2·`SLOT_W`-1 and increments on each fall event, wrapping to 0.
  - Left slot is k = 0..`SLOT_W`-1; right slot is k = `SLOT_W`..2·`SLOT_W`-1.
- **LRCLK** (I2S one-bit lead):
  - LRCLK = 1 for k in [`SLOT_W`-1, 2·`SLOT_W`-2].
  - LRCLK = 0 otherwise.
  - It therefore changes one BCLK before each channel's MSB.
- **SDATA.**
  - For slot offset p = k mod `SLOT_W`: SDATA = sample[`SAMPLE_W`-1-p] when p < `SAMPLE_W`, else 0.
  - The left sample is used in the left slot, the right sample in the right slot.
  - Implemented as two shift registers, or one 2·`SLOT_W` register, shifted on fall events.
- **Holding register (1 entry).**
  - `in_ready` = !full.
  - Accept on `in_valid && in_ready`: capture both channels and set full.
  - Inputs are ignored while full.
- **Frame load.** Occurs on the fall event where k wraps to 0:
  - If full: copy holding → shift register and clear full. `in_ready` returns to 1 on the next cycle.
  - If empty: pulse `underrun` and load the underrun pattern (see Configuration).
  - If empty at load and `in_valid` is high on the same cycle: the sample is accepted into the holding register, is not used by the current frame, and goes out in the next frame. `underrun` still pulses.
- **Reset values** (all, the cycle after `rst` is sampled high):
  - BCLK = 0, LRCLK = 0, SDATA = 0, `in_ready` = 1, `underrun` = 0.
  - `div_cnt` = 0, `k` = 2·`SLOT_W`-1, full = 0, shift/last-frame registers = 0.
  - Reset mid-frame aborts the frame immediately and discards any held sample.

## Timing
- BCLK period = 2·`CLK_DIV` clk cycles. Frame = 2·`SLOT_W`·2·`CLK_DIV` = 768 cycles at defaults, ≈ 65.1 kHz.
- After `rst` deasserts (cycle 0 = first non-reset edge):
  - BCLK rises at edge `CLK_DIV`.
  - The first fall event is at edge 2·`CLK_DIV`. It is the first frame load, with k = 0 and the left MSB on SDATA.
- SDATA and LRCLK are stable for a full BCLK period around each rising edge, which is where the DAC samples.
- Handshake: accept latency is 1 cycle (full is visible on the next edge). Throughput is one sample per frame.
- `underrun` is high for exactly one clk cycle, aligned with the load fall event.

## Configuration
- Macro: `I2S_TX_UNDERRUN_REPEAT_EN`.
- Defined:
  - On underrun, the previous frame's left/right pair (kept in a last-frame register) is retransmitted.
  - Before any sample has been received, the retransmitted pair is zero.
- Undefined:
  - On underrun, both slots are transmitted as all zeros.
  - No last-frame register is synthesized.
- `underrun` pulses identically in both builds.

## Test plan
- **Reset:** hold `rst` 3 cycles, then release.
  - Outputs are at their reset values: BCLK = 0, LRCLK = 0, SDATA = 0, `in_ready` = 1.
  - BCLK rises at cycle 6 and falls at cycle 12.
  - `underrun` pulses at cycle 12 because no sample is queued.
- **Bit order:** queue left = 18'h2AAAA, right = 18'h00001 before cycle 12; capture SDATA on BCLK rising edges.
  - Frame 1 (the frame after the cycle-12 load): left is 101010…10 (18 bits) then 14 zeros; right is 17 zeros, a 1, then 14 zeros.
  - LRCLK rises at k = 31 and falls at k = 63.
- **Backpressure:** drive `in_valid` continuously with distinct samples A, B.
  - A is accepted; `in_ready` drops.
  - B is held off until the next load edge. `in_ready` = 1 on the cycle after the load, and B is accepted then.
  - A and B are transmitted in consecutive frames with no `underrun`.
- **Underrun:** after one sample, provide no more.
  - `underrun` pulses once per frame.
  - SDATA is all zeros without the macro, or the previous sample repeated with `I2S_TX_UNDERRUN_REPEAT_EN`.
- **Simultaneous:** assert `in_valid` exactly on the load edge while empty.
  - `underrun` pulses and the sample is accepted.
  - The sample is transmitted in the following frame, not the current one.
- **Mid-frame reset:** assert `rst` at k = 20 with a sample held.
  - The next cycle shows all reset values and `in_ready` = 1.
  - The held sample is never transmitted.
